// File: rtl/correlator_sweep_controller.sv
// correlator_sweep_controller
// Steps the 8-lane correlator through a sweep of code-delay bins. For each bin
// it loads the PRBS offset, clears and runs one integration, then streams the
// captured |corr|^2 over a valid/ready port.
// Optional build macro CORR_SWEEP_PEAK_EN adds peak_valid/peak_bin/peak_magnitude
// tracking of the strongest bin in the sweep.
module correlator_sweep_controller #(
  parameter int CODE_ADDR_WIDTH = 16,
  parameter int OUTPUT_WIDTH    = 32,
  parameter int BIN_WIDTH       = 10,
  parameter int TIMEOUT_WIDTH   = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sweep_start,
  input  logic                       sweep_abort,
  input  logic [BIN_WIDTH-1:0]       cfg_num_bins,
  input  logic [CODE_ADDR_WIDTH-1:0] cfg_bin_step,
  input  logic [CODE_ADDR_WIDTH-1:0] cfg_code_length,
  input  logic [TIMEOUT_WIDTH-1:0]   cfg_timeout,
  output logic [CODE_ADDR_WIDTH-1:0] code_offset,
  output logic                       code_load,
  output logic                       corr_cfg_enable,
  output logic                       corr_cfg_clear,
  output logic [CODE_ADDR_WIDTH-1:0] corr_cfg_code_length,
  input  logic                       corr_valid,
  input  logic [OUTPUT_WIDTH-1:0]    corr_magnitude_sq,
  input  logic                       overflow_detected,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [BIN_WIDTH-1:0]       res_bin,
  output logic [OUTPUT_WIDTH-1:0]    res_magnitude,
  output logic                       res_overflow,
  output logic                       sweep_busy,
  output logic                       sweep_done,
  output logic                       timeout_error
`ifdef CORR_SWEEP_PEAK_EN
  ,
  output logic                       peak_valid,
  output logic [BIN_WIDTH-1:0]       peak_bin,
  output logic [OUTPUT_WIDTH-1:0]    peak_magnitude
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, EMIT, DONE} state_t;

  state_t                     state;
  logic [BIN_WIDTH-1:0]       num_bins_q;
  logic [BIN_WIDTH-1:0]       bin;
  logic [CODE_ADDR_WIDTH-1:0] step_q;
  logic [TIMEOUT_WIDTH-1:0]   timeout_q;
  logic [TIMEOUT_WIDTH-1:0]   watchdog;
  logic [CODE_ADDR_WIDTH:0]   offset_sum;
  logic [CODE_ADDR_WIDTH:0]   length_ext;
  logic [CODE_ADDR_WIDTH-1:0] next_offset;
  logic                       last_bin;
  logic                       watchdog_expired;
`ifdef CORR_SWEEP_PEAK_EN
  logic                       any_result;
`endif

  // Next-bin offset with wrap, last-bin and watchdog-expiry decodes.
  // NOTE: every variable here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    offset_sum       = {1'b0, code_offset} + {1'b0, step_q};
    length_ext       = {1'b0, corr_cfg_code_length};
    next_offset      = (offset_sum >= length_ext) ? CODE_ADDR_WIDTH'(offset_sum - length_ext)
                                                  : CODE_ADDR_WIDTH'(offset_sum);
    last_bin         = (bin == num_bins_q - BIN_WIDTH'(1));
    watchdog_expired = (timeout_q != '0) && (watchdog == timeout_q - TIMEOUT_WIDTH'(1));
  end

  // Sweep sequencer: state, latched config and all registered outputs.
  // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      num_bins_q           <= '0;
      bin                  <= '0;
      step_q               <= '0;
      timeout_q            <= '0;
      watchdog             <= '0;
      code_offset          <= '0;
      code_load            <= 1'b0;
      corr_cfg_enable      <= 1'b0;
      corr_cfg_clear       <= 1'b0;
      corr_cfg_code_length <= '0;
      res_valid            <= 1'b0;
      res_bin              <= '0;
      res_magnitude        <= '0;
      res_overflow         <= 1'b0;
      sweep_busy           <= 1'b0;
      sweep_done           <= 1'b0;
      timeout_error        <= 1'b0;
`ifdef CORR_SWEEP_PEAK_EN
      any_result           <= 1'b0;
      peak_valid           <= 1'b0;
      peak_bin             <= '0;
      peak_magnitude       <= '0;
`endif
    end else begin
      code_load      <= 1'b0;
      corr_cfg_clear <= 1'b0;
      sweep_done     <= 1'b0;
      if (state != IDLE && sweep_abort) begin
        // Abort wins over everything: drop to idle and discard any pending result.
        state                <= IDLE;
        bin                  <= '0;
        watchdog             <= '0;
        code_offset          <= '0;
        corr_cfg_enable      <= 1'b0;
        corr_cfg_code_length <= '0;
        res_valid            <= 1'b0;
        res_bin              <= '0;
        res_magnitude        <= '0;
        res_overflow         <= 1'b0;
        sweep_busy           <= 1'b0;
`ifdef CORR_SWEEP_PEAK_EN
        any_result           <= 1'b0;
        peak_valid           <= 1'b0;
        peak_bin             <= '0;
        peak_magnitude       <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (sweep_start) begin
              num_bins_q           <= cfg_num_bins;
              step_q               <= cfg_bin_step;
              corr_cfg_code_length <= cfg_code_length;
              timeout_q            <= cfg_timeout;
              bin                  <= '0;
              code_offset          <= '0;
              watchdog             <= '0;
              timeout_error        <= 1'b0;
              sweep_busy           <= 1'b1;
`ifdef CORR_SWEEP_PEAK_EN
              any_result           <= 1'b0;
              peak_valid           <= 1'b0;
              peak_bin             <= '0;
              peak_magnitude       <= '0;
`endif
              if (cfg_num_bins == '0) begin
                state      <= DONE;
                sweep_done <= 1'b1;
              end else begin
                state          <= LOAD;
                code_load      <= 1'b1;
                corr_cfg_clear <= 1'b1;
              end
            end
          end
          LOAD: begin
            state           <= RUN;
            corr_cfg_enable <= 1'b1;
          end
          RUN: begin
            if (corr_valid) begin
              state           <= EMIT;
              corr_cfg_enable <= 1'b0;
              res_valid       <= 1'b1;
              res_bin         <= bin;
              res_magnitude   <= corr_magnitude_sq;
              res_overflow    <= overflow_detected;
            end else if (watchdog_expired) begin
              state           <= DONE;
              corr_cfg_enable <= 1'b0;
              timeout_error   <= 1'b1;
              sweep_done      <= 1'b1;
`ifdef CORR_SWEEP_PEAK_EN
              peak_valid      <= any_result;
`endif
            end else begin
              watchdog <= watchdog + TIMEOUT_WIDTH'(1);
            end
          end
          EMIT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
`ifdef CORR_SWEEP_PEAK_EN
              any_result <= 1'b1;
              if (res_magnitude > peak_magnitude) begin
                peak_magnitude <= res_magnitude;
                peak_bin       <= res_bin;
              end
`endif
              if (last_bin) begin
                state      <= DONE;
                sweep_done <= 1'b1;
`ifdef CORR_SWEEP_PEAK_EN
                peak_valid <= 1'b1;
`endif
              end else begin
                state          <= LOAD;
                bin            <= bin + BIN_WIDTH'(1);
                code_offset    <= next_offset;
                watchdog       <= '0;
                code_load      <= 1'b1;
                corr_cfg_clear <= 1'b1;
              end
            end
          end
          DONE: begin
            state      <= IDLE;
            sweep_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_correlator_sweep_controller.sv
// Self-checking bench for correlator_sweep_controller. The bench plays the
// correlator: it answers each enabled integration after a random latency with
// a magnitude from a per-sweep table, and compares every bin against offsets
// computed as (bin*step) mod length. Build with +define+CORR_SWEEP_PEAK_EN to
// also check peak tracking.
module tb_correlator_sweep_controller;
  localparam int CAW = 16;
  localparam int OW  = 32;
  localparam int BW  = 10;
  localparam int TW  = 24;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sweep_start = 1'b0;
  logic           sweep_abort = 1'b0;
  logic [BW-1:0]  cfg_num_bins = '0;
  logic [CAW-1:0] cfg_bin_step = '0;
  logic [CAW-1:0] cfg_code_length = '0;
  logic [TW-1:0]  cfg_timeout = '0;
  logic [CAW-1:0] code_offset;
  logic           code_load;
  logic           corr_cfg_enable;
  logic           corr_cfg_clear;
  logic [CAW-1:0] corr_cfg_code_length;
  logic           corr_valid = 1'b0;
  logic [OW-1:0]  corr_magnitude_sq = '0;
  logic           overflow_detected = 1'b0;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [BW-1:0]  res_bin;
  logic [OW-1:0]  res_magnitude;
  logic           res_overflow;
  logic           sweep_busy;
  logic           sweep_done;
  logic           timeout_error;
`ifdef CORR_SWEEP_PEAK_EN
  logic           peak_valid;
  logic [BW-1:0]  peak_bin;
  logic [OW-1:0]  peak_magnitude;
`endif

  int total = 0;
  int bad   = 0;
  logic [OW-1:0] mags[$];
  logic          ovfs[$];

  always #5 clk = ~clk;

  correlator_sweep_controller #(
    .CODE_ADDR_WIDTH(CAW), .OUTPUT_WIDTH(OW), .BIN_WIDTH(BW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sweep_start(sweep_start), .sweep_abort(sweep_abort),
    .cfg_num_bins(cfg_num_bins), .cfg_bin_step(cfg_bin_step),
    .cfg_code_length(cfg_code_length), .cfg_timeout(cfg_timeout),
    .code_offset(code_offset), .code_load(code_load),
    .corr_cfg_enable(corr_cfg_enable), .corr_cfg_clear(corr_cfg_clear),
    .corr_cfg_code_length(corr_cfg_code_length),
    .corr_valid(corr_valid), .corr_magnitude_sq(corr_magnitude_sq),
    .overflow_detected(overflow_detected),
    .res_valid(res_valid), .res_ready(res_ready), .res_bin(res_bin),
    .res_magnitude(res_magnitude), .res_overflow(res_overflow),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .timeout_error(timeout_error)
`ifdef CORR_SWEEP_PEAK_EN
    , .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_magnitude(peak_magnitude)
`endif
  );

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // True when every output sits at its reset value.
  function automatic logic quiet();
    logic q;
    q = (code_offset == '0) && !code_load && !corr_cfg_enable && !corr_cfg_clear &&
        (corr_cfg_code_length == '0) && !res_valid && (res_bin == '0) &&
        (res_magnitude == '0) && !res_overflow && !sweep_busy && !sweep_done && !timeout_error;
`ifdef CORR_SWEEP_PEAK_EN
    q = q && !peak_valid && (peak_bin == '0) && (peak_magnitude == '0);
`endif
    return q;
  endfunction

  task automatic fill_random(input int nb);
    mags.delete();
    ovfs.delete();
    for (int i = 0; i < nb; i++) begin
      mags.push_back($urandom);
      ovfs.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  // Peak reference: first bin holding the largest magnitude among the emitted ones.
  task automatic check_peak(input string tag, input int emitted);
`ifdef CORR_SWEEP_PEAK_EN
    logic [OW-1:0] best;
    int            best_bin;
    best = '0;
    best_bin = 0;
    for (int i = 0; i < emitted; i++)
      if (mags[i] > best) begin
        best = mags[i];
        best_bin = i;
      end
    check({tag, "_peak_valid"}, peak_valid, emitted > 0);
    check({tag, "_peak_bin"}, peak_bin, best_bin);
    check({tag, "_peak_mag"}, peak_magnitude, best);
`else
    if (emitted < 0) $display("%s", tag);
`endif
  endtask

  // Runs one sweep against mags/ovfs. hang_at: bin left unanswered until the
  // watchdog fires; abort_at: abort raised (with corr_valid) in RUN of that bin;
  // reset_at: rst_n pulsed while that bin's result is pending. -1 disables each.
  task automatic run_sweep(input int nb, input int step, input int len, input int tmo,
                           input int stall_min, input int stall_max, input int lat_max,
                           input int hang_at, input int abort_at, input int reset_at);
    int emitted;
    int d;
    int s;
    emitted = 0;
    cfg_num_bins    = BW'(nb);
    cfg_bin_step    = CAW'(step);
    cfg_code_length = CAW'(len);
    cfg_timeout     = TW'(tmo);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    // Config must have been latched; change it under the sweep.
    cfg_num_bins    = BW'($urandom);
    cfg_bin_step    = CAW'($urandom);
    cfg_code_length = CAW'($urandom);
    cfg_timeout     = TW'($urandom_range(1, 3));
    check("start_busy", sweep_busy, 1);
    check("start_tmo_clear", timeout_error, 0);
`ifdef CORR_SWEEP_PEAK_EN
    check("start_peak_clear", {peak_valid, peak_bin, peak_magnitude}, 0);
`endif
    if (nb == 0) begin
      check("empty_done", sweep_done, 1);
      check("empty_no_load", code_load, 0);
      tick();
      check("empty_done_pulse", sweep_done, 0);
      check("empty_busy_1cyc", sweep_busy, 0);
      check("empty_no_res", res_valid, 0);
      return;
    end
    for (int b = 0; b < nb; b++) begin
      check("load", code_load, 1);
      check("clear", corr_cfg_clear, 1);
      check("load_enable_low", corr_cfg_enable, 0);
      check("offset", code_offset, CAW'((b * step) % len));
      check("code_length", corr_cfg_code_length, CAW'(len));
      tick();
      check("enable", corr_cfg_enable, 1);
      check("load_pulse", code_load, 0);
      if (b == hang_at) begin
        repeat (tmo - 1) tick();
        check("pre_timeout", timeout_error, 0);
        check("pre_timeout_enable", corr_cfg_enable, 1);
        tick();
        check("timeout", timeout_error, 1);
        check("timeout_done", sweep_done, 1);
        check("timeout_no_res", res_valid, 0);
        check("timeout_enable_low", corr_cfg_enable, 0);
        check_peak("timeout", emitted);
        tick();
        check("timeout_done_pulse", sweep_done, 0);
        check("timeout_idle", sweep_busy, 0);
        check("timeout_sticky", timeout_error, 1);
        return;
      end
      d = $urandom_range(0, lat_max);
      repeat (d) tick();
      if (b == abort_at) begin
        sweep_abort = 1'b1;
        corr_valid = 1'b1;
        corr_magnitude_sq = $urandom;
        tick();
        sweep_abort = 1'b0;
        corr_valid = 1'b0;
        check("abort_quiet", quiet(), 1);
        tick();
        check("abort_no_done", sweep_done, 0);
        check("abort_stays_idle", quiet(), 1);
        return;
      end
      corr_valid = 1'b1;
      corr_magnitude_sq = mags[b];
      overflow_detected = ovfs[b];
      tick();
      corr_valid = 1'b0;
      corr_magnitude_sq = $urandom;
      overflow_detected = ~ovfs[b];
      check("res_valid", res_valid, 1);
      check("res_payload", {res_bin, res_magnitude, res_overflow}, {BW'(b), mags[b], ovfs[b]});
      check("run_enable_drop", corr_cfg_enable, 0);
      if (b == reset_at) begin
        rst_n = 1'b0;
        tick();
        check("reset_quiet", quiet(), 1);
        rst_n = 1'b1;
        tick();
        check("reset_no_done", quiet(), 1);
        return;
      end
      s = $urandom_range(stall_min, stall_max);
      repeat (s) begin
        corr_valid = 1'($urandom_range(0, 1));
        tick();
        check("stall_valid", res_valid, 1);
        check("stall_payload", {res_bin, res_magnitude, res_overflow}, {BW'(b), mags[b], ovfs[b]});
        check("stall_no_load", code_load, 0);
      end
      corr_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      emitted++;
      check("handshake_drop", res_valid, 0);
    end
    check("done", sweep_done, 1);
    check("done_busy", sweep_busy, 1);
    check("done_no_tmo", timeout_error, 0);
    check_peak("done", emitted);
    tick();
    check("done_pulse", sweep_done, 0);
    check("done_idle", sweep_busy, 0);
    check_peak("hold", emitted);
  endtask

  initial begin
    int nb;
    int len;
    int lat;
    rst_n = 1'b0;
    repeat (2) tick();
    check("reset_state", quiet(), 1);
    rst_n = 1'b1;
    tick();

    // Basic sweep with a tie at the peak (bins 1 and 3 both 50).
    fill_random(4);
    mags = '{32'd10, 32'd50, 32'd30, 32'd50};
    run_sweep(4, 100, 1024, 0, 0, 0, 3, -1, -1, -1);
    // Offset wrap past the code length: 0,100,200,44.
    fill_random(4);
    run_sweep(4, 100, 256, 0, 0, 2, 2, -1, -1, -1);
    // Back-pressure: ready held low 5 cycles per result.
    fill_random(3);
    run_sweep(3, 7, 50, 0, 5, 5, 2, -1, -1, -1);
    // Correlator never answers: watchdog on the first bin, then on a later bin.
    fill_random(2);
    run_sweep(2, 5, 100, 20, 0, 0, 0, 0, -1, -1);
    fill_random(3);
    run_sweep(3, 5, 100, 20, 0, 1, 3, 1, -1, -1);
    // Empty sweep.
    run_sweep(0, 1, 10, 0, 0, 0, 0, -1, -1, -1);
    // Abort in RUN of bin 2, reset while a result is pending, then a clean sweep.
    fill_random(4);
    run_sweep(4, 10, 100, 0, 0, 1, 2, -1, 2, -1);
    fill_random(3);
    run_sweep(3, 10, 100, 0, 0, 1, 2, -1, -1, 1);
    fill_random(2);
    run_sweep(2, 30, 40, 0, 0, 1, 2, -1, -1, -1);
    // Random sweeps; odd ones answer as late as the watchdog allows.
    for (int k = 0; k < 6; k++) begin
      nb  = $urandom_range(1, 6);
      len = $urandom_range(1, 3000);
      lat = $urandom_range(0, 8);
      fill_random(nb);
      run_sweep(nb, $urandom_range(0, len - 1), len, (k % 2) ? lat + 1 : 0,
                0, 3, lat, -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
